// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: groups the three buses that meet at the memory controller.
//   Instruction fetch: if_valid/if_addr in, if_ready/if_data out.
//   Load/store data:   d_valid/d_wr/d_size/d_addr/d_value in, d_ready/d_res out.
//   Memory port:       mem_din in, mem_dout/mem_a/mem_wr out.
// The master modport is the surrounding system: the front end plus the RAM/IO bus.
// The slave modport is the controller.
//
// Handshake:
//   - A requester raises *_valid and keeps its fields stable until it sees the
//     matching *_ready.
//   - *_ready is a single-cycle pulse. Result data (if_data/d_res) is valid in
//     that cycle and holds until the next completion.
//   - A new request may be presented on the cycle the ready is observed.
interface mem_ctrl_if;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_valid;
  logic        d_wr;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_value;
  logic        d_ready;
  logic [31:0] d_res;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport master (
    output if_valid, if_addr, d_valid, d_wr, d_size, d_addr, d_value, mem_din,
    input  if_ready, if_data, d_ready, d_res, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_valid, if_addr, d_valid, d_wr, d_size, d_addr, d_value, mem_din,
    output if_ready, if_data, d_ready, d_res, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: owns the 8-bit unified RAM/IO port.
//   It arbitrates between instruction fetch and the load/store data port.
//   Each 1/2/4-byte access is split into little-endian byte cycles.
// Ports:
//   clk_in, rst_in (async, active-low)
//   rdy_in         : global freeze when low
//   io_buffer_full : stalls writes that target IO space
//   flush          : cancels an instruction fetch
//   bus            : fetch, data and memory signals (mem_ctrl_if.slave)
//   state_dbg      : current FSM state (IDLE=0, READ=1, WRITE=2, DONE=3)
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       io_buffer_full,
  input  logic       flush,
  mem_ctrl_if.slave  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  n_q;
  logic        sext_q;
  logic        wr_q;
  logic        grant_d;       // 1: current access belongs to the data port
  logic        last_grant_d;  // 1: data port won the most recent grant
  logic [31:0] base_q;
  logic [31:0] value_q;
  logic [31:0] rdata_q;
  logic        if_ready_q;
  logic        d_ready_q;
  logic [31:0] if_data_q;
  logic [31:0] d_res_q;

  logic        io_block;
  logic        want_if;
  logic        pick_d;
  logic [2:0]  idx;
  logic [7:0]  wbyte;

  function automatic logic [2:0] size_n(input logic [1:0] s);
    case (s)
      2'd0:    size_n = 3'd1;
      2'd1:    size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] n,
                                         input logic sx);
    case (n)
      3'd1:    extend = {{24{sx & r[7]}}, r[7:0]};
      3'd2:    extend = {{16{sx & r[15]}}, r[15:0]};
      default: extend = r;
    endcase
  endfunction

  assign io_block = (base_q[17:16] == IO_ADDR_HI) && io_buffer_full;

  // A flush in IDLE suppresses the fetch request for that edge.
  assign want_if = bus.if_valid && !flush;

  // On a tie the data port wins unless it also won the previous grant.
  assign pick_d = bus.d_valid && (!want_if || !last_grant_d);

  // Read byte index driven on mem_a.
  //   - A byte's data returns one cycle after its address. The capture for byte
  //     cnt-1 therefore happens while the address for byte cnt is on the bus.
  //   - During a freeze the in-flight address is re-driven. The RAM then keeps
  //     returning the byte still owed, so the capture after the freeze is correct.
  //   - The final capture cycle (cnt == n) has no new address. It parks on the
  //     last byte.
  always_comb begin
    idx = cnt;
    if (state == READ && (cnt == n_q || (!rdy_in && cnt != 3'd0))) idx = cnt - 3'd1;
  end

  always_comb begin
    wbyte = 8'd0;
    case (cnt[1:0])
      2'd0: wbyte = value_q[7:0];
      2'd1: wbyte = value_q[15:8];
      2'd2: wbyte = value_q[23:16];
      2'd3: wbyte = value_q[31:24];
      default: wbyte = 8'd0;
    endcase
  end

  assign bus.mem_a    = (state == READ || state == WRITE) ? base_q + {29'd0, idx} : 32'd0;
  assign bus.mem_dout = (state == WRITE) ? wbyte : 8'd0;
  assign bus.mem_wr   = (state == WRITE) && rdy_in && !io_block;
  assign bus.if_ready = if_ready_q;
  assign bus.if_data  = if_data_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.d_res    = d_res_q;
  assign state_dbg    = state;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      n_q          <= 3'd0;
      sext_q       <= 1'b0;
      wr_q         <= 1'b0;
      grant_d      <= 1'b0;
      last_grant_d <= 1'b0;
      base_q       <= 32'd0;
      value_q      <= 32'd0;
      rdata_q      <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      if_data_q    <= 32'd0;
      d_res_q      <= 32'd0;
    end else if (rdy_in) begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 3'd0;
          rdata_q <= 32'd0;
          if (pick_d) begin
            base_q       <= bus.d_addr;
            value_q      <= bus.d_value;
            wr_q         <= bus.d_wr;
            n_q          <= size_n(bus.d_size[1:0]);
            sext_q       <= bus.d_size[2];
            grant_d      <= 1'b1;
            last_grant_d <= 1'b1;
            state        <= bus.d_wr ? WRITE : READ;
          end else if (want_if) begin
            base_q       <= bus.if_addr;
            value_q      <= 32'd0;
            wr_q         <= 1'b0;
            n_q          <= 3'd4;
            sext_q       <= 1'b0;
            grant_d      <= 1'b0;
            last_grant_d <= 1'b0;
            state        <= READ;
          end
        end
        READ: begin
          if (!grant_d && flush) begin
            state <= IDLE;
          end else begin
            case (cnt)
              3'd1:    rdata_q[7:0]   <= bus.mem_din;
              3'd2:    rdata_q[15:8]  <= bus.mem_din;
              3'd3:    rdata_q[23:16] <= bus.mem_din;
              3'd4:    rdata_q[31:24] <= bus.mem_din;
              default: ;
            endcase
            if (cnt == n_q) state <= DONE;
            else            cnt   <= cnt + 3'd1;
          end
        end
        WRITE: begin
          // A blocked IO write keeps the same byte on the bus for a retry.
          if (!io_block) begin
            if (cnt == n_q - 3'd1) state <= DONE;
            else                   cnt   <= cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (grant_d) begin
            d_ready_q <= 1'b1;
            d_res_q   <= wr_q ? 32'd0 : extend(rdata_q, n_q, sext_q);
          end else if (!flush) begin
            if_ready_q <= 1'b1;
            if_data_q  <= rdata_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] value;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rdy_in;
  logic       io_buffer_full;
  logic       flush;
  logic [1:0] state_dbg;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rdy_in         (rdy_in),
    .io_buffer_full (io_buffer_full),
    .flush          (flush),
    .bus            (bus.slave),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model: data returns one cycle after address ----------------
  logic [7:0] ram [0:4095];

  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write cycle is compared against the expected {addr, byte} queue.
  always @(negedge clk) begin
    if (rst_n && bus.mem_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, bus.mem_a, bus.mem_dout}, 64'd0);
      end else begin
        check("mem_write", {24'd0, bus.mem_a, bus.mem_dout}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n           = 1'b0;
    rdy_in          = 1'b1;
    io_buffer_full  = 1'b0;
    flush           = 1'b0;
    bus.if_valid    = 1'b0;
    bus.if_addr     = 32'd0;
    bus.d_valid     = 1'b0;
    bus.d_wr        = 1'b0;
    bus.d_size      = 3'd0;
    bus.d_addr      = 32'd0;
    bus.d_value     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_wr",   bus.mem_wr,   0);
    check("rst_mem_a",    bus.mem_a,    0);
    check("rst_mem_dout", bus.mem_dout, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_if_data",  bus.if_data,  0);
    check("rst_d_ready",  bus.d_ready,  0);
    check("rst_d_res",    bus.d_res,    0);
    check("rst_state",    state_dbg,    0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_data(input vec_t v, input int io_cycles, input int stall_at,
                         input int stall_cycles);
    int  m;
    bit  got;
    int  n;
    @(negedge clk);
    bus.d_valid = 1'b1;
    bus.d_wr    = v.wr;
    bus.d_size  = v.size;
    bus.d_addr  = v.addr;
    bus.d_value = v.value;
    n = (v.size[1:0] == 2'd0) ? 1 : (v.size[1:0] == 2'd1) ? 2 : 4;
    if (v.wr) begin
      for (int k = 0; k < n; k++) begin
        logic [31:0] a;
        logic [31:0] sh;
        a  = v.addr + k;
        sh = v.value >> (8 * k);
        exp_q.push_back({a, sh[7:0]});
      end
    end
    @(posedge clk);
    #1;
    m   = 0;
    got = 0;
    io_buffer_full = (io_cycles > 0);
    rdy_in = !(stall_cycles > 0 && stall_at == 0);
    while (!got && m < 40) begin
      @(posedge clk);
      #1;
      m++;
      if (bus.d_ready) begin
        got = 1;
      end else begin
        io_buffer_full = (m < io_cycles);
        rdy_in = !(m >= stall_at && m < stall_at + stall_cycles);
      end
    end
    io_buffer_full = 1'b0;
    rdy_in         = 1'b1;
    bus.d_valid    = 1'b0;
    check("d_latency", m, v.exp_lat);
    check("d_res", bus.d_res, v.exp_res);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                          input int exp_lat);
    int m;
    @(negedge clk);
    bus.if_valid = 1'b1;
    bus.if_addr  = addr;
    @(posedge clk);
    m = 0;
    do begin
      @(posedge clk);
      #1;
      m++;
    end while (!bus.if_ready && m < 40);
    bus.if_valid = 1'b0;
    check("if_latency", m, exp_lat);
    check("if_data", bus.if_data, exp_data);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[10];
  vec_t v;
  logic [31:0] order;
  int nreq;
  int cyc;
  int seen;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h11;
    ram[12'h101] = 8'h22;
    ram[12'h102] = 8'h33;
    ram[12'h103] = 8'h44;
    ram[12'h200] = 8'h80;
    bus.mem_din  = 8'h00;

    //        wr    size     addr          value         exp_res       lat
    vecs[0] = '{1'b0, 3'b100, 32'h00000200, 32'h00000000, 32'hFFFFFF80, 3};
    vecs[1] = '{1'b0, 3'b000, 32'h00000200, 32'h00000000, 32'h00000080, 3};
    vecs[2] = '{1'b1, 3'b010, 32'h000003FC, 32'hDEADBEEF, 32'h00000000, 5};
    vecs[3] = '{1'b0, 3'b010, 32'h000003FC, 32'h00000000, 32'hDEADBEEF, 6};
    vecs[4] = '{1'b0, 3'b101, 32'h000003FE, 32'h00000000, 32'hFFFFDEAD, 4};
    vecs[5] = '{1'b0, 3'b001, 32'h000003FC, 32'h00000000, 32'h0000BEEF, 4};
    vecs[6] = '{1'b1, 3'b001, 32'hFFFFFFFE, 32'h00001234, 32'h00000000, 3};
    vecs[7] = '{1'b0, 3'b101, 32'hFFFFFFFE, 32'h00000000, 32'h00001234, 4};
    vecs[8] = '{1'b1, 3'b000, 32'h00000210, 32'hFFFFFF5A, 32'h00000000, 2};
    vecs[9] = '{1'b0, 3'b100, 32'h00000210, 32'h00000000, 32'h0000005A, 3};

    do_reset();

    // Word fetch: 4 reads, ready 6 cycles after the grant edge.
    do_fetch(32'h00000100, 32'h44332211, 6);

    for (int i = 0; i < 10; i++) do_data(vecs[i], 0, 0, 0);

    // IO-space byte store held off by a full UART buffer for 3 cycles.
    v = '{1'b1, 3'b000, 32'h00030000, 32'h000000A5, 32'h00000000, 5};
    do_data(v, 3, 0, 0);

    // Global freeze for 2 cycles in the middle of a word read.
    v = '{1'b0, 3'b010, 32'h000003FC, 32'h00000000, 32'hDEADBEEF, 8};
    do_data(v, 0, 2, 2);

    // Flush during the second READ cycle of a fetch.
    @(negedge clk);
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h00000100;
    @(posedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.if_valid = 1'b0;
    check("flush_state_idle", state_dbg, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.if_ready) seen++;
    end
    check("flush_no_if_ready", seen, 0);

    // Flush while idle keeps a fetch from being granted.
    @(negedge clk);
    bus.if_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    check("flush_idle_no_grant", state_dbg, 0);
    bus.if_valid = 1'b0;
    flush        = 1'b0;

    // Both requesters valid continuously from reset: grants alternate, data first.
    do_reset();
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h00000100;
    bus.d_valid  = 1'b1;
    bus.d_wr     = 1'b0;
    bus.d_size   = 3'b010;
    bus.d_addr   = 32'h000003FC;
    order = 32'd0;
    nreq  = 0;
    cyc   = 0;
    while (nreq < 4 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.d_ready) begin
        order = {order[23:0], 8'h64};
        nreq++;
        check("arb_d_res", bus.d_res, 32'hDEADBEEF);
      end
      if (bus.if_ready) begin
        order = {order[23:0], 8'h69};
        nreq++;
        check("arb_if_data", bus.if_data, 32'h44332211);
      end
    end
    bus.if_valid = 1'b0;
    bus.d_valid  = 1'b0;
    check("arb_order", order, 32'h64696469);

    // Reset in the middle of a word store: the access is dropped.
    @(negedge clk);
    bus.d_valid = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_size  = 3'b010;
    bus.d_addr  = 32'h000003FC;
    bus.d_value = 32'h01020304;
    exp_q.push_back({32'h000003FC, 8'h04});
    exp_q.push_back({32'h000003FD, 8'h03});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    bus.d_valid = 1'b0;
    check("midrst_mem_wr",   bus.mem_wr,   0);
    check("midrst_mem_a",    bus.mem_a,    0);
    check("midrst_mem_dout", bus.mem_dout, 0);
    check("midrst_d_res",    bus.d_res,    0);
    check("midrst_state",    state_dbg,    0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.d_ready) seen++;
    end
    check("midrst_no_d_ready", seen, 0);

    check("writes_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
